// File: rtl/cipher_output_holder.sv
// Output holding stage: collects one block of cipher words, flags it complete to the
// interface controller, serves it word-by-word to the pins, and zeroises on IDLE.
module cipher_output_holder #(
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        interface_state,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_next,
  output logic [DATA_W-1:0] out_data,
  output logic              output_is_ready,
  output logic              overflow_err
);

  localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [1:0] IST_PROCESSING = 2'd1;
  localparam logic [1:0] IST_DONE       = 2'd2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } holder_state_t;

  holder_state_t     state_reg, state_next;
  logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
  logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
  logic              ready_reg, ready_next;
  logic              ovf_reg, ovf_next;
  logic [DATA_W-1:0] word_reg [BLOCK_WORDS];

  logic clear;
  logic processing;
  logic accept;

  // IDLE and the unused encoding 3 both zeroise the holder.
  assign clear      = (interface_state != IST_PROCESSING) && (interface_state != IST_DONE);
  assign processing = (interface_state == IST_PROCESSING);
  assign in_ready   = (state_reg != FULL) && processing;
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_next  = state_reg;
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    ready_next  = ready_reg;
    ovf_next    = ovf_reg;
    if (clear) begin
      state_next  = EMPTY;
      wr_idx_next = '0;
      rd_idx_next = '0;
      ready_next  = 1'b0;
      ovf_next    = 1'b0;
    end else begin
      unique case (state_reg)
        EMPTY, FILLING: begin
          if (accept) begin
            if (wr_idx_reg == LAST_IDX) begin
              state_next  = FULL;
              wr_idx_next = '0;
              ready_next  = 1'b1;
            end else begin
              state_next  = FILLING;
              wr_idx_next = wr_idx_reg + IDX_W'(1);
            end
          end
        end
        FULL: begin
          if (out_next) begin
            rd_idx_next = (rd_idx_reg == LAST_IDX) ? '0 : rd_idx_reg + IDX_W'(1);
          end
          // Not clearing here implies the controller is not IDLE.
          if (in_valid) begin
            ovf_next = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg  <= EMPTY;
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      ready_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_idx_reg <= wr_idx_next;
      rd_idx_reg <= rd_idx_next;
      ready_reg  <= ready_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Each word is its own register so the whole block can be zeroised in one edge.
  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          word_reg[gi] <= '0;
        end else if (clear) begin
          word_reg[gi] <= '0;
        end else if (accept && (wr_idx_reg == IDX_W'(gi))) begin
          word_reg[gi] <= in_data;
        end
      end
    end
  endgenerate

  assign out_data        = (state_reg == FULL) ? word_reg[rd_idx_reg] : '0;
  assign output_is_ready = ready_reg;
  assign overflow_err    = ovf_reg;

endmodule

// File: tb/tb_cipher_output_holder.sv
// Directed bench for cipher_output_holder: a queue-based block model checked every
// cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_cipher_output_holder;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] interface_state = 2'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_next = 1'b0;
  logic [7:0] out_data;
  logic       output_is_ready;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  cipher_output_holder #(.DATA_W(8), .BLOCK_WORDS(4)) dut (
    .clk(clk),
    .nrst(nrst),
    .interface_state(interface_state),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_next(out_next),
    .out_data(out_data),
    .output_is_ready(output_is_ready),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the block is just a list of accepted words; it is complete at 4 entries.
  logic [7:0] m_words[$];
  bit         m_full = 1'b0;
  int         m_rd = 0;
  bit         m_ovf = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst || interface_state == 2'd0 || interface_state == 2'd3) begin
      m_words.delete();
      m_full = 1'b0;
      m_rd   = 0;
      m_ovf  = 1'b0;
    end else if (m_full) begin
      if (in_valid) m_ovf = 1'b1;
      if (out_next) m_rd = (m_rd + 1) % 4;
    end else if (in_valid && interface_state == 2'd1) begin
      m_words.push_back(in_data);
      if (m_words.size() == 4) m_full = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready", {7'd0, in_ready}, {7'd0, (!m_full && interface_state == 2'd1)});
    chk("m_out_data", out_data, m_full ? m_words[m_rd] : 8'h00);
    chk("m_output_is_ready", {7'd0, output_is_ready}, {7'd0, m_full});
    chk("m_overflow_err", {7'd0, overflow_err}, {7'd0, m_ovf});
  end

  task automatic setin(input logic [1:0] ist, input logic v, input logic [7:0] d, input logic nx);
    interface_state = ist;
    in_valid        = v;
    in_data         = d;
    out_next        = nx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] w0, w1, w2, w3);
    logic [7:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      setin(2'd1, 1'b1, w[i], 1'b0);
      #1 chk("fill_in_ready", {7'd0, in_ready}, 8'd1);
      step();
    end
    setin(2'd1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] t2_exp [5];
    logic [7:0] t4_exp [4];
    t2_exp = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    t4_exp = '{8'h22, 8'h33, 8'h44, 8'h11};

    // Reset state
    step(); step();
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_output_is_ready", {7'd0, output_is_ready}, 8'd0);
    chk("rst_overflow_err", {7'd0, overflow_err}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // T1: back-to-back fill completes in 4 cycles
    fill(8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_in_ready_full", {7'd0, in_ready}, 8'd0);
    chk("t1_output_is_ready", {7'd0, output_is_ready}, 8'd1);
    chk("t1_out_data", out_data, 8'h11);

    // T2: readout wraps
    for (int i = 0; i < 5; i++) begin
      setin(2'd1, 1'b0, 8'h00, 1'b1);
      step();
      chk("t2_readout", out_data, t2_exp[i]);
    end
    setin(2'd1, 1'b0, 8'h00, 1'b0);
    step();

    // T3: one IDLE edge zeroises; the next write lands in word 0
    setin(2'd0, 1'b0, 8'h00, 1'b0);
    step();
    chk("t3_output_is_ready", {7'd0, output_is_ready}, 8'd0);
    chk("t3_out_data", out_data, 8'h00);
    chk("t3_in_ready", {7'd0, in_ready}, 8'd0);
    fill(8'h55, 8'h66, 8'h77, 8'h88);
    chk("t3_word0", out_data, 8'h55);

    // T4: overflow while FULL in DONE; block intact; IDLE clears the flag
    setin(2'd0, 1'b0, 8'h00, 1'b0);
    step();
    fill(8'h11, 8'h22, 8'h33, 8'h44);
    setin(2'd2, 1'b1, 8'hAA, 1'b0);
    step();
    setin(2'd2, 1'b0, 8'h00, 1'b0);
    chk("t4_overflow_set", {7'd0, overflow_err}, 8'd1);
    chk("t4_first", out_data, 8'h11);
    for (int i = 0; i < 4; i++) begin
      setin(2'd2, 1'b0, 8'h00, 1'b1);
      step();
      chk("t4_readout", out_data, t4_exp[i]);
    end
    setin(2'd2, 1'b0, 8'h00, 1'b0);
    step();
    chk("t4_overflow_sticky", {7'd0, overflow_err}, 8'd1);
    setin(2'd0, 1'b0, 8'h00, 1'b0);
    step();
    chk("t4_overflow_cleared", {7'd0, overflow_err}, 8'd0);

    // T5: gated writes while EMPTY, then a fill paused by DONE
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 3; i++) begin
        setin((s == 0) ? 2'd0 : 2'd2, 1'b1, 8'h77, 1'b0);
        #1 chk("t5_in_ready_gated", {7'd0, in_ready}, 8'd0);
        step();
        chk("t5_no_overflow", {7'd0, overflow_err}, 8'd0);
        chk("t5_not_ready", {7'd0, output_is_ready}, 8'd0);
      end
    end
    setin(2'd1, 1'b1, 8'h01, 1'b0); step();
    setin(2'd1, 1'b1, 8'h02, 1'b0); step();
    setin(2'd2, 1'b1, 8'h99, 1'b0); step();
    setin(2'd2, 1'b1, 8'h98, 1'b1); step();
    chk("t5_paused", {7'd0, output_is_ready}, 8'd0);
    setin(2'd1, 1'b1, 8'h03, 1'b0); step();
    setin(2'd1, 1'b1, 8'h04, 1'b0); step();
    setin(2'd1, 1'b0, 8'h00, 1'b0);
    chk("t5_resumed_ready", {7'd0, output_is_ready}, 8'd1);
    chk("t5_resumed_word0", out_data, 8'h01);
    setin(2'd1, 1'b0, 8'h00, 1'b1); step();
    setin(2'd1, 1'b0, 8'h00, 1'b1); step();
    chk("t5_word2", out_data, 8'h03);
    setin(2'd1, 1'b0, 8'h00, 1'b0);

    // T6: async reset mid-fill, then a clean fill
    setin(2'd0, 1'b0, 8'h00, 1'b0); step();
    setin(2'd1, 1'b1, 8'hC1, 1'b0); step();
    setin(2'd1, 1'b1, 8'hC2, 1'b0); step();
    #2;
    setin(2'd0, 1'b0, 8'h00, 1'b0);
    nrst = 1'b0;
    #1;
    chk("t6_out_data", out_data, 8'h00);
    chk("t6_output_is_ready", {7'd0, output_is_ready}, 8'd0);
    chk("t6_overflow_err", {7'd0, overflow_err}, 8'd0);
    chk("t6_in_ready", {7'd0, in_ready}, 8'd0);
    step();
    #2 nrst = 1'b1;
    step();
    fill(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    chk("t6_refill_ready", {7'd0, output_is_ready}, 8'd1);
    chk("t6_refill_word0", out_data, 8'hD1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
